// File: rtl/idea_pkg.sv
// Shared constants, FSM state type and key-schedule helper for the IDEA engine.
package idea_pkg;

  localparam int          W           = 16;
  localparam int          NUM_SUBKEYS = 52;
  localparam int unsigned KEY_ROT     = 25;
  localparam int unsigned KEY_BITS    = 128;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    OUT
  } state_t;

  // Subkey idx = word (idx mod 8) of the user key rotated left by 25*(idx div 8).
  // Word 0 sits at the MSBs.
  function automatic logic [15:0] subkey(input logic [127:0] user_key,
                                         input int unsigned  idx);
    int unsigned  sh;
    logic [127:0] rot;
    sh  = (KEY_ROT * (idx / 8)) % KEY_BITS;
    // A shift by the full width yields zero, so sh == 0 needs no special case.
    rot = (user_key << sh) | (user_key >> (KEY_BITS - sh));
    return rot[127 - 16 * (idx % 8) -: 16];
  endfunction

endpackage

// File: rtl/idea_mulmod.sv
// Combinational multiply modulo 2^W+1, with an all-zero operand/result meaning 2^W.
module idea_mulmod #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [2*W-1:0] prod;
  logic [W-1:0]   lo;
  logic [W-1:0]   hi;

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign lo   = prod[W-1:0];
  assign hi   = prod[2*W-1:W];

  // Zero operands stand for 2^W == -1, so the product is just 1 - other.
  // Otherwise lo - hi (plus 2^W+1 on borrow) reduces mod 2^W+1; a result of
  // 2^W wraps naturally to the zero encoding.
  always_comb begin
    y = '0;
    if (a == '0)
      y = ONE - b;
    else if (b == '0)
      y = ONE - a;
    else if (lo >= hi)
      y = lo - hi;
    else
      y = lo - hi + ONE;
  end

endmodule

// File: rtl/idea_iter_core.sv
// Iterative IDEA encryption: one full round per clock, then the output transform.
module idea_iter_core
  import idea_pkg::*;
#(
  parameter int ROUNDS         = 8,
  parameter int W              = 16,
  parameter bit CHECK_ONLY_STD = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [4*W-1:0] text,
  input  logic [127:0]   key,
  output logic           busy,
  output logic           done,
  output logic [4*W-1:0] encrypted_text
);

  if (CHECK_ONLY_STD && W != 16) begin : g_width_check
    $error("idea_iter_core supports only W == 16");
  end

  if (ROUNDS < 1 || ROUNDS > 8) begin : g_rounds_check
    $error("idea_iter_core ROUNDS must be within 1..8");
  end

  localparam logic [3:0]  LAST     = 4'(ROUNDS - 1);
  localparam int unsigned OUT_BASE = 6 * ROUNDS;

  state_t         state;
  state_t         state_nx;
  logic           load;
  logic           step;
  logic           fin;
  logic [3:0]     rnd;
  logic [W-1:0]   a, b, c, d;
  logic [127:0]   key_q;
  logic [4*W-1:0] out_buf;
  logic           out_vld;

  int unsigned    base;
  logic [W-1:0]   k1, k2, k3, k4, k5, k6;
  logic [W-1:0]   m0y, m1y, m2a, m2y, m3a, m3y;
  logic [W-1:0]   tb, tc, e, f;
  logic [4*W-1:0] y;

  // Subkey selection for the current round, or the output transform keys in OUT.
  always_comb begin
    base = (state == OUT) ? OUT_BASE : 32'(rnd) * 6;
    k1   = subkey(key_q, base);
    k2   = subkey(key_q, base + 1);
    k3   = subkey(key_q, base + 2);
    k4   = subkey(key_q, base + 3);
    k5   = subkey(key_q, base + 4);
    k6   = subkey(key_q, base + 5);
  end

  // Multipliers 0 and 1 serve both the round input layer and the output transform.
  idea_mulmod #(.W(W)) u_mul0 (.a(a),   .b(k1), .y(m0y));
  idea_mulmod #(.W(W)) u_mul1 (.a(d),   .b(k4), .y(m1y));
  idea_mulmod #(.W(W)) u_mul2 (.a(m2a), .b(k5), .y(m2y));
  idea_mulmod #(.W(W)) u_mul3 (.a(m3a), .b(k6), .y(m3y));

  assign tb  = b + k2;
  assign tc  = c + k3;
  assign m2a = m0y ^ tc;
  assign m3a = (tb ^ m1y) + m2y;
  assign f   = m3y;
  assign e   = m2y + m3y;
  assign y   = {m0y, c + k2, b + k3, m1y};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        step = 1'b1;
        if (rnd == LAST) state_nx = OUT;
      end
      OUT: begin
        fin      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, round counter and the registered result/done stage.
  // Result is captured in OUT and published one edge later, so the FSM is
  // already idle (and accepting start) in the cycle done is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a              <= '0;
      b              <= '0;
      c              <= '0;
      d              <= '0;
      key_q          <= '0;
      rnd            <= '0;
      out_buf        <= '0;
      out_vld        <= 1'b0;
      encrypted_text <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy    <= (state_nx != IDLE);
      out_vld <= fin;
      done    <= out_vld;
      if (out_vld) encrypted_text <= out_buf;
      if (fin)     out_buf        <= y;
      if (load) begin
        a     <= text[4*W-1 -: W];
        b     <= text[3*W-1 -: W];
        c     <= text[2*W-1 -: W];
        d     <= text[W-1:0];
        key_q <= key;
        rnd   <= '0;
      end else if (step) begin
        a   <= m0y ^ f;
        b   <= tc ^ f;
        c   <= tb ^ e;
        d   <= m1y ^ e;
        rnd <= (rnd == LAST) ? '0 : rnd + 4'd1;
      end
    end
  end

endmodule
